// File: rtl/ow_romid_sequencer.sv
// ow_romid_sequencer: drives a DS1WM 1-Wire master through its register port
// to read the 64-bit ROMID of a single slave.
// The sequence is: program the divisor, 1-Wire reset with presence check,
// Read ROM (0x33), then read 8 bytes.
// Optional CRC8 check is enabled by defining OW_ROMID_CRC_CHECK_EN.
module ow_romid_sequencer #(
  parameter logic [7:0] CLK_DIV      = 8'h8D,
  parameter int         POLL_TIMEOUT = 20000,
  parameter int         TOW_W        = 16
) (
  input  logic        CLK,
  input  logic        MR,
  input  logic        start,
  output logic [2:0]  bus_addr,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] romid,
  output logic [1:0]  err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_DIV, S_WR_RST, S_PD_RD, S_PD_SMP, S_TX,
    S_RBF_RD, S_RBF_SMP, S_RX_RD, S_RX_SMP, S_FINISH
  } state_e;

  localparam logic [TOW_W-1:0] TOW_LAST = TOW_W'(POLL_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;       // 8 = command slot, 0..7 = ROMID byte
  logic [TOW_W-1:0]  tow_q, tow_d;
  logic [63:0]       shadow_q, shadow_d;
  logic [63:0]       romid_q, romid_d;
  logic [1:0]        err_q, err_d;
  logic              tow_hit;

`ifdef OW_ROMID_CRC_CHECK_EN
  logic [7:0] crc_q, crc_d, crc_nx;

  // Dallas CRC8 (x^8+x^5+x^4+1), reflected, one byte LSB first
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else             r = r >> 1;
    end
    return r;
  endfunction
`endif

  // Strobes come straight from state so MR drops them without waiting for a clock
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tow_d     = '0;
    shadow_d  = shadow_q;
    romid_d   = romid_q;
    err_d     = err_q;
    bus_addr  = 3'd0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    bus_wdata = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;
    tow_hit   = (tow_q == TOW_LAST);
`ifdef OW_ROMID_CRC_CHECK_EN
    crc_d     = crc_q;
    crc_nx    = crc8(crc_q, bus_rdata);
`endif
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_WR_DIV;
          err_d   = 2'd0;
          cnt_d   = 4'd8;
`ifdef OW_ROMID_CRC_CHECK_EN
          crc_d   = 8'h00;
`endif
        end
      end
      S_WR_DIV: begin
        bus_addr = 3'd4; bus_wr = 1'b1; bus_wdata = CLK_DIV;
        state_d  = S_WR_RST;
      end
      S_WR_RST: begin
        bus_addr = 3'd0; bus_wr = 1'b1; bus_wdata = 8'h01;
        state_d  = S_PD_RD;
      end
      S_PD_RD: begin
        bus_addr = 3'd2; bus_rd = 1'b1;
        tow_d    = tow_q + TOW_W'(1);
        if (tow_hit) begin state_d = S_FINISH; err_d = 2'd3; end
        else         state_d = S_PD_SMP;
      end
      S_PD_SMP: begin
        tow_d = tow_q + TOW_W'(1);
        if (bus_rdata[0]) begin
          if (bus_rdata[1]) begin state_d = S_FINISH; err_d = 2'd1; end
          else              state_d = S_TX;
        end else if (tow_hit) begin
          state_d = S_FINISH; err_d = 2'd3;
        end else begin
          state_d = S_PD_RD;
        end
      end
      S_TX: begin
        bus_addr  = 3'd1; bus_wr = 1'b1;
        bus_wdata = (cnt_q == 4'd8) ? 8'h33 : 8'hFF;
        state_d   = S_RBF_RD;
      end
      S_RBF_RD: begin
        bus_addr = 3'd2; bus_rd = 1'b1;
        tow_d    = tow_q + TOW_W'(1);
        if (tow_hit) begin state_d = S_FINISH; err_d = 2'd3; end
        else         state_d = S_RBF_SMP;
      end
      S_RBF_SMP: begin
        tow_d = tow_q + TOW_W'(1);
        if (bus_rdata[4])  state_d = S_RX_RD;
        else if (tow_hit) begin state_d = S_FINISH; err_d = 2'd3; end
        else               state_d = S_RBF_RD;
      end
      S_RX_RD: begin
        bus_addr = 3'd1; bus_rd = 1'b1;
        state_d  = S_RX_SMP;
      end
      S_RX_SMP: begin
        if (cnt_q[3]) begin
          // echo of the Read ROM command, nothing to keep
          cnt_d   = 4'd0;
          state_d = S_TX;
        end else begin
          shadow_d[{cnt_q[2:0], 3'b000} +: 8] = bus_rdata;
`ifdef OW_ROMID_CRC_CHECK_EN
          crc_d = crc_nx;
`endif
          if (cnt_q == 4'd7) begin
            // result is settled here so romid/err are valid alongside done
            state_d = S_FINISH;
            romid_d = shadow_d;
`ifdef OW_ROMID_CRC_CHECK_EN
            err_d   = (crc_nx != 8'h00) ? 2'd2 : 2'd0;
`else
            err_d   = 2'd0;
`endif
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_TX;
          end
        end
      end
      S_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by MR
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tow_q    <= '0;
      shadow_q <= '0;
      romid_q  <= '0;
      err_q    <= '0;
`ifdef OW_ROMID_CRC_CHECK_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tow_q    <= tow_d;
      shadow_q <= shadow_d;
      romid_q  <= romid_d;
      err_q    <= err_d;
`ifdef OW_ROMID_CRC_CHECK_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign romid = romid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ow_romid_sequencer.sv
// Scoreboard bench for ow_romid_sequencer with a small DS1WM register model.
module tb_ow_romid_sequencer;
  localparam int P = 500;

  logic        CLK = 1'b0;
  logic        MR = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  bus_addr;
  logic        bus_wr, bus_rd;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        busy, done;
  logic [63:0] romid;
  logic [1:0]  err;

  ow_romid_sequencer #(.CLK_DIV(8'h8D), .POLL_TIMEOUT(P), .TOW_W(16)) dut (
    .CLK(CLK), .MR(MR), .start(start), .bus_addr(bus_addr), .bus_wr(bus_wr),
    .bus_rd(bus_rd), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .busy(busy), .done(done), .romid(romid), .err(err));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, ff_seen = 0, t_ff3 = 0;
  logic [10:0] wq[$];   // expected {addr, wdata}
  logic [65:0] rq[$];   // expected {err, romid}

  always @(posedge CLK) cyc++;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // DS1WM model: flags, RX buffer, slave bytes
  logic [7:0] bytes [8] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
  logic       pd = 1'b0, rbf = 1'b0, pdr_cfg = 1'b0;
  logic [1:0] pd_wait = 2'd0;
  logic [3:0] ff_cnt = 4'd0;
  logic [7:0] rx = 8'h00;
  int         block_at = 0;

  always @(posedge CLK) begin
    if (bus_wr) begin
      if (bus_addr == 3'd0) begin
        pd <= 1'b1; pd_wait <= 2'd2; ff_cnt <= 4'd0; rbf <= 1'b0;
      end else if (bus_addr == 3'd1) begin
        if (bus_wdata == 8'hFF) begin
          rx     <= bytes[ff_cnt[2:0]];
          ff_cnt <= ff_cnt + 4'd1;
          rbf    <= ((int'(ff_cnt) + 1) != block_at);
        end else begin
          rx <= 8'h00; rbf <= 1'b1;
        end
      end
    end
    if (bus_rd) begin
      if (bus_addr == 3'd2) begin
        if (pd_wait != 2'd0) begin
          pd_wait <= pd_wait - 2'd1; bus_rdata <= 8'h00;
        end else begin
          bus_rdata <= {3'b000, rbf, 2'b00, pdr_cfg & pd, pd};
          pd <= 1'b0; rbf <= 1'b0;
        end
      end else if (bus_addr == 3'd1) bus_rdata <= rx;
      else bus_rdata <= 8'h00;
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a write or pulses done
  always @(negedge CLK) begin
    if (!MR) begin
      if (bus_wr && bus_rd) begin
        n_chk++; $display("FAIL strobe_excl: got wr=1 rd=1 expected one at most");
      end
      if (bus_wr) begin
        if (bus_addr == 3'd0) ff_seen = 0;
        if (bus_addr == 3'd1 && bus_wdata == 8'hFF) begin
          ff_seen++;
          if (ff_seen == 3) t_ff3 = cyc;
        end
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected: got addr %0d data %h expected none", bus_addr, bus_wdata);
        end else chk("bus_wr", {bus_addr, bus_wdata}, {55'd0, wq.pop_front()});
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got err %0d romid %h expected no done", err, romid);
        end else chk("result", {err, romid}, rq.pop_front());
      end
    end
  end

  task automatic push_writes(input bit with_tx, input int n_ff);
    wq.push_back({3'd4, 8'h8D});
    wq.push_back({3'd0, 8'h01});
    if (with_tx) begin
      wq.push_back({3'd1, 8'h33});
      for (int i = 0; i < n_ff; i++) wq.push_back({3'd1, 8'hFF});
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim, input string nm);
    int i;
    i = 0;
    while (done_cnt == base && i < lim) begin @(negedge CLK); i++; end
    chk(nm, 66'(done_cnt != base), 66'd1);
  endtask

  localparam logic [63:0] ID_A2 = 64'hA200_0000_01B8_1C02;
  localparam logic [63:0] ID_A3 = 64'hA300_0000_01B8_1C02;

  initial begin
    int base, i;
    repeat (3) @(negedge CLK);
    chk("rst_outs", {busy, done, bus_wr, bus_rd, bus_addr, bus_wdata, err}, 66'd0);
    chk("rst_romid", romid, 66'd0);
    MR = 1'b0;
    repeat (2) @(negedge CLK);

    // normal read, with a second start while busy that must be ignored
    push_writes(1, 8);
    rq.push_back({2'd0, ID_A2});
    base = done_cnt;
    pulse_start();
    repeat (2) @(negedge CLK);
    chk("busy_high", busy, 66'd1);
    repeat (4) @(negedge CLK);
    pulse_start();
    wait_done(base, 400, "done_normal");
    repeat (60) @(negedge CLK);
    chk("one_done", done_cnt - base, 66'd1);
    chk("wq_drained_normal", wq.size(), 66'd0);
    chk("idle_busy", busy, 66'd0);

    // no presence: only divisor and reset writes, romid kept
    pdr_cfg = 1'b1;
    push_writes(0, 0);
    rq.push_back({2'd1, ID_A2});
    base = done_cnt;
    pulse_start();
    wait_done(base, 400, "done_nopd");
    repeat (10) @(negedge CLK);
    chk("wq_drained_nopd", wq.size(), 66'd0);
    pdr_cfg = 1'b0;

    // corrupted last byte
    bytes[7] = 8'hA3;
    push_writes(1, 8);
`ifdef OW_ROMID_CRC_CHECK_EN
    rq.push_back({2'd2, ID_A3});
`else
    rq.push_back({2'd0, ID_A3});
`endif
    base = done_cnt;
    pulse_start();
    wait_done(base, 400, "done_crc");
    repeat (5) @(negedge CLK);

    // RBF stuck after the third FF: timeout, romid kept
    block_at = 3;
    push_writes(1, 3);
    rq.push_back({2'd3, ID_A3});
    base = done_cnt;
    pulse_start();
    wait_done(base, P + 400, "done_timeout");
    chk("tmo_latency", done_cyc - t_ff3, 66'(P + 1));
    chk("wq_drained_tmo", wq.size(), 66'd0);
    block_at = 0;
    bytes[7] = 8'hA2;
    repeat (5) @(negedge CLK);

    // MR during byte 4: abort, no done, then a clean rerun
    push_writes(1, 8);
    base = done_cnt;
    pulse_start();
    i = 0;
    while (ff_seen < 4 && i < 200) begin @(negedge CLK); i++; end
    chk("mr_reach_byte4", 66'(ff_seen >= 4), 66'd1);
    #2 MR = 1'b1;
    #1 chk("mr_async", {bus_wr, bus_rd, busy, done}, 66'd0);
    @(negedge CLK);
    chk("mr_outs", {busy, done, bus_wr, bus_rd, bus_addr, bus_wdata, err}, 66'd0);
    chk("mr_romid", romid, 66'd0);
    wq.delete();
    @(negedge CLK) MR = 1'b0;
    repeat (60) @(negedge CLK);
    chk("mr_no_done", done_cnt - base, 66'd0);
    push_writes(1, 8);
    rq.push_back({2'd0, ID_A2});
    base = done_cnt;
    pulse_start();
    wait_done(base, 400, "done_after_mr");
    repeat (5) @(negedge CLK);
    chk("wq_drained_rerun", wq.size(), 66'd0);
    chk("rq_drained", rq.size(), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
